oric_ram_arbiter: RTL and testbench
===================================

Name: oric_ram_arbiter

Overview:
Shares the single toggle-handshake SDRAM port between two requesters: the Oric CPU/ULA RAM bus and the floppy controller's track-buffer DMA. It detects CPU access events from level cs/oe/we signals, queues one request per requester and grants them in priority order. A starvation counter guarantees forward progress for the FDC. It sits in the clk_mem domain, between oricatmos/FDC and the sdram instance.

Parameters:
ADDR_W, 24, SDRAM byte-address width on the mem_* side.
FDC_BASE, 24'h010000, byte offset added to fdc_ad so disk data never aliases the 64 KB CPU space.
STARVE_MAX, 64, clk_mem cycles an FDC request may wait before it pre-empts CPU priority.

Ports:
clk_mem  in  1  SDRAM clock; all logic is on the rising edge.
reset_n  in  1  asynchronous active-low reset.
cpu_cs  in  1  CPU RAM select (level).
cpu_oe  in  1  CPU read enable (level).
cpu_we  in  1  CPU write enable (level).
cpu_ad  in  16  CPU byte address.
cpu_d  in  8  CPU write data.
cpu_q  out  8  last CPU read byte (held).
fdc_req  in  1  one-cycle FDC access request.
fdc_we  in  1  FDC write (1) or read (0), sampled with fdc_req.
fdc_ad  in  16  FDC buffer byte address, sampled with fdc_req.
fdc_d  in  8  FDC write data, sampled with fdc_req.
fdc_ack  out  1  one-cycle completion pulse.
fdc_q  out  8  FDC read byte, valid with fdc_ack and held afterwards.
fdc_overrun  out  1  sticky: fdc_req arrived while an FDC access was pending or in flight.
mem_req  out  1  toggle request to the SDRAM port.
mem_ack  in  1  toggle acknowledge; a transfer is complete when mem_ack == mem_req.
mem_a  out  ADDR_W  byte address.
mem_we  out  1  write strobe.
mem_ds  out  2  byte lanes: write → 2'b01 if a[0]=0, 2'b10 if a[0]=1; read → 2'b11.
mem_d  out  16  write data, byte replicated on both lanes.
mem_q  in  16  read data.

Behaviour:
- Reset state: all outputs 0, state INIT, pending flags clear, starvation counter 0.
- INIT (one cycle): mem_req <= mem_ack, so an access in flight when reset was asserted is absorbed; then go to IDLE.
- CPU event detection uses registered cs&oe, cs&we and cpu_ad. An event is any of:
  - rising edge of cs&oe;
  - rising edge of cs&we;
  - cs&oe high while cpu_ad differs from its registered copy.
- On a CPU event: capture ad, we, d into the CPU slot and set cpu_pend. A newer event overwrites an unissued slot; the previous slot is dropped, newest wins.
- On fdc_req:
  - if FDC is idle (no fdc_pend, not FDC_WAIT): capture into the FDC slot and set fdc_pend;
  - otherwise: ignore the request and set fdc_overrun, which stays set until reset.
- Starvation counter: increments each cycle fdc_pend is set and not granted, saturating at STARVE_MAX. It clears when FDC is granted.
- IDLE grant, evaluated each cycle:
  - if fdc_pend and counter == STARVE_MAX: grant FDC;
  - else if cpu_pend: grant CPU;
  - else if fdc_pend: grant FDC.
  - Grant actions: drive mem_a/mem_we/mem_ds/mem_d from the slot, toggle mem_req, clear that slot's pend flag, enter CPU_WAIT or FDC_WAIT.
  - CPU mem_a = zero-extended cpu_ad. FDC mem_a = FDC_BASE + fdc_ad, modulo 2^ADDR_W.
  - mem_* are held stable until completion.
- CPU_WAIT / FDC_WAIT: wait for mem_ack == mem_req. The completion cycle returns to IDLE, so a new grant is possible on the next cycle; back-to-back grant spacing is at least 1 idle cycle.
- CPU read completion: cpu_q <= the mem_q byte selected by a[0] (1 → [15:8], 0 → [7:0]).
- FDC completion: fdc_ack pulses for 1 cycle. On a read, fdc_q is loaded the same cycle. On a write, fdc_q is unchanged.
- Writes never update cpu_q.
- Events arriving while a request is in flight are queued in the slots and do not disturb mem_*.
- Asserting reset_n low mid-transfer aborts immediately; the transfer's data is discarded.
- No timeout: a lost ack stalls the block. This is acceptable.

Decomposition:
- Package oric_ram_pkg holds:
  - the state enum (INIT, IDLE, CPU_WAIT, FDC_WAIT);
  - the slot struct {addr, we, data};
  - the lane-select helper function.
- One natural sub-module: oric_cpu_evt_detect, which produces the registered cs/oe/we/address-change event pulse.
- The arbiter FSM and the two slots stay in the top.

Test Plan:
- Reset held with mem_ack=1, then released → mem_req=1 after INIT, and no request is issued with idle inputs.
- CPU read at 16'h1235 (cs,oe rising); sdram toggles ack after 5 cycles with mem_q=16'hAB12 → mem_ds=2'b11, mem_a=24'h001235, cpu_q=8'hAB.
- CPU write 8'h5A to 16'h0400 → exactly one toggle, mem_we=1, mem_ds=2'b01, mem_d=16'h5A5A.
- fdc_req write 8'h77 at 16'h0010 and CPU read event in the same cycle → CPU granted first, then FDC at mem_a=24'h010010; fdc_ack pulses once.
- CPU address changes every 4 cycles continuously with fdc_req pending → FDC granted no later than STARVE_MAX (64) cycles plus one in-flight CPU access.
- Second fdc_req during FDC_WAIT → fdc_overrun=1, only one FDC toggle; reset_n low mid-CPU_WAIT → mem_we=0 immediately, INIT resync, no stale cpu_q update.

Source files
------------

// File: rtl/oric_ram_pkg.sv
// Shared types and helpers for the Oric CPU/FDC SDRAM arbiter.
// Holds the arbiter state encoding, the request slot layout and byte-lane helpers.
package oric_ram_pkg;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_CPU_WAIT,
    ST_FDC_WAIT
  } arb_state_t;

  typedef struct packed {
    logic [15:0] addr;
    logic        we;
    logic [7:0]  data;
  } slot_t;

  // Writes touch only the addressed byte lane; reads fetch the whole word.
  function automatic logic [1:0] lane_sel(input logic we, input logic a0);
    if (!we) return 2'b11;
    return a0 ? 2'b10 : 2'b01;
  endfunction

  function automatic logic [7:0] lane_byte(input logic [15:0] q, input logic a0);
    return a0 ? q[15:8] : q[7:0];
  endfunction

endpackage

// File: rtl/oric_cpu_evt_detect.sv
// Turns the CPU's level cs/oe/we/address bus into a single access-event pulse.
// Fires on a read or write strobe rising, or on an address change during a read.
module oric_cpu_evt_detect (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_cs,
  input  logic        i_oe,
  input  logic        i_we,
  input  logic [15:0] i_ad,
  output logic        o_evt,
  output logic        o_we
);

  logic        w_rd;
  logic        w_wr;
  logic        r_rd;
  logic        r_wr;
  logic [15:0] r_ad;

  assign w_rd = i_cs & i_oe;
  assign w_wr = i_cs & i_we;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd <= 1'b0;
      r_wr <= 1'b0;
      r_ad <= '0;
    end else begin
      r_rd <= w_rd;
      r_wr <= w_wr;
      r_ad <= i_ad;
    end
  end

  assign o_evt = (w_rd & ~r_rd) | (w_wr & ~r_wr) | (w_rd & (i_ad != r_ad));
  assign o_we  = w_wr;

endmodule

// File: rtl/oric_ram_arbiter.sv
// Shares one toggle-handshake SDRAM port between the Oric CPU bus and the FDC DMA.
// CPU has priority, but an FDC request that has waited STARVE_MAX cycles pre-empts it.
module oric_ram_arbiter
  import oric_ram_pkg::*;
#(
  parameter int          ADDR_W     = 24,
  parameter int unsigned FDC_BASE   = 32'h0001_0000,
  parameter int          STARVE_MAX = 64
) (
  input  logic              i_clk_mem,
  input  logic              i_reset_n,
  input  logic              i_cpu_cs,
  input  logic              i_cpu_oe,
  input  logic              i_cpu_we,
  input  logic [15:0]       i_cpu_ad,
  input  logic [7:0]        i_cpu_d,
  output logic [7:0]        o_cpu_q,
  input  logic              i_fdc_req,
  input  logic              i_fdc_we,
  input  logic [15:0]       i_fdc_ad,
  input  logic [7:0]        i_fdc_d,
  output logic              o_fdc_ack,
  output logic [7:0]        o_fdc_q,
  output logic              o_fdc_overrun,
  output logic              o_mem_req,
  input  logic              i_mem_ack,
  output logic [ADDR_W-1:0] o_mem_a,
  output logic              o_mem_we,
  output logic [1:0]        o_mem_ds,
  output logic [15:0]       o_mem_d,
  input  logic [15:0]       i_mem_q
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  arb_state_t        r_state, w_state_nxt;
  slot_t             r_cpu_slot, w_cpu_slot_nxt;
  slot_t             r_fdc_slot, w_fdc_slot_nxt;
  logic              r_cpu_pend, w_cpu_pend_nxt;
  logic              r_fdc_pend, w_fdc_pend_nxt;
  logic [CNT_W-1:0]  r_starve, w_starve_nxt;
  logic              r_mem_req, w_mem_req_nxt;
  logic [ADDR_W-1:0] r_mem_a, w_mem_a_nxt;
  logic              r_mem_we, w_mem_we_nxt;
  logic [1:0]        r_mem_ds, w_mem_ds_nxt;
  logic [15:0]       r_mem_d, w_mem_d_nxt;
  logic [7:0]        r_cpu_q, w_cpu_q_nxt;
  logic [7:0]        r_fdc_q, w_fdc_q_nxt;
  logic              r_fdc_ack, w_fdc_ack_nxt;
  logic              r_overrun, w_overrun_nxt;
  logic              w_grant_cpu, w_grant_fdc;
  logic              w_cpu_evt, w_cpu_we;
  logic              w_done;

  oric_cpu_evt_detect u_evt (
    .i_clk   (i_clk_mem),
    .i_rst_n (i_reset_n),
    .i_cs    (i_cpu_cs),
    .i_oe    (i_cpu_oe),
    .i_we    (i_cpu_we),
    .i_ad    (i_cpu_ad),
    .o_evt   (w_cpu_evt),
    .o_we    (w_cpu_we)
  );

  assign w_done = (i_mem_ack == r_mem_req);

  always_comb begin
    w_state_nxt    = r_state;
    w_cpu_slot_nxt = r_cpu_slot;
    w_fdc_slot_nxt = r_fdc_slot;
    w_cpu_pend_nxt = r_cpu_pend;
    w_fdc_pend_nxt = r_fdc_pend;
    w_starve_nxt   = r_starve;
    w_mem_req_nxt  = r_mem_req;
    w_mem_a_nxt    = r_mem_a;
    w_mem_we_nxt   = r_mem_we;
    w_mem_ds_nxt   = r_mem_ds;
    w_mem_d_nxt    = r_mem_d;
    w_cpu_q_nxt    = r_cpu_q;
    w_fdc_q_nxt    = r_fdc_q;
    w_fdc_ack_nxt  = 1'b0;
    w_overrun_nxt  = r_overrun;
    w_grant_cpu    = 1'b0;
    w_grant_fdc    = 1'b0;

    case (r_state)
      ST_INIT: begin
        w_mem_req_nxt = i_mem_ack;
        w_state_nxt   = ST_IDLE;
      end
      ST_IDLE: begin
        if (r_fdc_pend && (r_starve == STARVE_LIM)) w_grant_fdc = 1'b1;
        else if (r_cpu_pend)                        w_grant_cpu = 1'b1;
        else if (r_fdc_pend)                        w_grant_fdc = 1'b1;

        if (w_grant_cpu) begin
          w_mem_a_nxt    = ADDR_W'(r_cpu_slot.addr);
          w_mem_we_nxt   = r_cpu_slot.we;
          w_mem_ds_nxt   = lane_sel(r_cpu_slot.we, r_cpu_slot.addr[0]);
          w_mem_d_nxt    = {r_cpu_slot.data, r_cpu_slot.data};
          w_mem_req_nxt  = ~r_mem_req;
          w_cpu_pend_nxt = 1'b0;
          w_state_nxt    = ST_CPU_WAIT;
        end
        if (w_grant_fdc) begin
          w_mem_a_nxt    = ADDR_W'(FDC_BASE) + ADDR_W'(r_fdc_slot.addr);
          w_mem_we_nxt   = r_fdc_slot.we;
          w_mem_ds_nxt   = lane_sel(r_fdc_slot.we, r_fdc_slot.addr[0]);
          w_mem_d_nxt    = {r_fdc_slot.data, r_fdc_slot.data};
          w_mem_req_nxt  = ~r_mem_req;
          w_fdc_pend_nxt = 1'b0;
          w_state_nxt    = ST_FDC_WAIT;
        end
      end
      ST_CPU_WAIT: begin
        if (w_done) begin
          w_state_nxt = ST_IDLE;
          if (!r_mem_we) w_cpu_q_nxt = lane_byte(i_mem_q, r_mem_a[0]);
        end
      end
      ST_FDC_WAIT: begin
        if (w_done) begin
          w_state_nxt   = ST_IDLE;
          w_fdc_ack_nxt = 1'b1;
          if (!r_mem_we) w_fdc_q_nxt = lane_byte(i_mem_q, r_mem_a[0]);
        end
      end
      default: w_state_nxt = ST_INIT;
    endcase

    if (w_grant_fdc)                                  w_starve_nxt = '0;
    else if (r_fdc_pend && (r_starve != STARVE_LIM))  w_starve_nxt = r_starve + CNT_W'(1);

    // Captures come after the grant so an arrival in the grant cycle re-arms the slot.
    if (w_cpu_evt) begin
      w_cpu_slot_nxt = '{addr: i_cpu_ad, we: w_cpu_we, data: i_cpu_d};
      w_cpu_pend_nxt = 1'b1;
    end
    if (i_fdc_req) begin
      if (!r_fdc_pend && (r_state != ST_FDC_WAIT)) begin
        w_fdc_slot_nxt = '{addr: i_fdc_ad, we: i_fdc_we, data: i_fdc_d};
        w_fdc_pend_nxt = 1'b1;
      end else begin
        w_overrun_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk_mem or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state    <= ST_INIT;
      r_cpu_slot <= '0;
      r_fdc_slot <= '0;
      r_cpu_pend <= 1'b0;
      r_fdc_pend <= 1'b0;
      r_starve   <= '0;
      r_mem_req  <= 1'b0;
      r_mem_a    <= '0;
      r_mem_we   <= 1'b0;
      r_mem_ds   <= '0;
      r_mem_d    <= '0;
      r_cpu_q    <= '0;
      r_fdc_q    <= '0;
      r_fdc_ack  <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cpu_slot <= w_cpu_slot_nxt;
      r_fdc_slot <= w_fdc_slot_nxt;
      r_cpu_pend <= w_cpu_pend_nxt;
      r_fdc_pend <= w_fdc_pend_nxt;
      r_starve   <= w_starve_nxt;
      r_mem_req  <= w_mem_req_nxt;
      r_mem_a    <= w_mem_a_nxt;
      r_mem_we   <= w_mem_we_nxt;
      r_mem_ds   <= w_mem_ds_nxt;
      r_mem_d    <= w_mem_d_nxt;
      r_cpu_q    <= w_cpu_q_nxt;
      r_fdc_q    <= w_fdc_q_nxt;
      r_fdc_ack  <= w_fdc_ack_nxt;
      r_overrun  <= w_overrun_nxt;
    end
  end

  assign o_cpu_q       = r_cpu_q;
  assign o_fdc_ack     = r_fdc_ack;
  assign o_fdc_q       = r_fdc_q;
  assign o_fdc_overrun = r_overrun;
  assign o_mem_req     = r_mem_req;
  assign o_mem_a       = r_mem_a;
  assign o_mem_we      = r_mem_we;
  assign o_mem_ds      = r_mem_ds;
  assign o_mem_d       = r_mem_d;

endmodule

// File: tb/tb_oric_ram_arbiter.sv
// Self-checking bench: toggle-handshake SDRAM model plus a byte-array reference memory.
// Directed scenarios first, then randomized CPU/FDC traffic with random SDRAM latency.
module tb_oric_ram_arbiter;

  localparam int          ADDR_W     = 24;
  localparam int unsigned FDC_BASE   = 32'h0001_0000;
  localparam int          STARVE_MAX = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_cs = 1'b0, cpu_oe = 1'b0, cpu_we = 1'b0;
  logic [15:0] cpu_ad = '0;
  logic [7:0]  cpu_d = '0;
  logic [7:0]  cpu_q;
  logic        fdc_req = 1'b0, fdc_we = 1'b0;
  logic [15:0] fdc_ad = '0;
  logic [7:0]  fdc_d = '0;
  logic        fdc_ack;
  logic [7:0]  fdc_q;
  logic        fdc_overrun;
  logic        mem_req;
  logic        mem_ack = 1'b1;
  logic [23:0] mem_a;
  logic        mem_we;
  logic [1:0]  mem_ds;
  logic [15:0] mem_d;
  logic [15:0] mem_q = '0;

  always #5 clk = ~clk;

  oric_ram_arbiter #(.ADDR_W(ADDR_W), .FDC_BASE(FDC_BASE), .STARVE_MAX(STARVE_MAX)) dut (
    .i_clk_mem(clk), .i_reset_n(rst_n),
    .i_cpu_cs(cpu_cs), .i_cpu_oe(cpu_oe), .i_cpu_we(cpu_we), .i_cpu_ad(cpu_ad), .i_cpu_d(cpu_d),
    .o_cpu_q(cpu_q),
    .i_fdc_req(fdc_req), .i_fdc_we(fdc_we), .i_fdc_ad(fdc_ad), .i_fdc_d(fdc_d),
    .o_fdc_ack(fdc_ack), .o_fdc_q(fdc_q), .o_fdc_overrun(fdc_overrun),
    .o_mem_req(mem_req), .i_mem_ack(mem_ack), .o_mem_a(mem_a), .o_mem_we(mem_we),
    .o_mem_ds(mem_ds), .o_mem_d(mem_d), .i_mem_q(mem_q)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Backing store of the SDRAM model, and the reference memory the bench predicts from.
  logic [7:0]  sd_mem  [0:131071];
  logic [7:0]  ref_mem [0:131071];
  logic        sd_busy = 1'b0;
  bit          sd_rand = 1'b0;
  int          sd_cnt = 0, sd_lat = 5, sd_done = 0;
  logic [23:0] cap_a;
  logic        cap_we, cap_req;
  logic [1:0]  cap_ds;
  logic [15:0] cap_d;
  logic [23:0] log_a  [$];
  logic        log_we [$];
  logic [1:0]  log_ds [$];
  logic [15:0] log_d  [$];
  int          cyc = 0;
  int          fdc_seen = -1;
  int          ack_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (fdc_ack === 1'b1) ack_cnt++;
    if (sd_busy) begin
      if (rst_n) begin
        check("hold_ctl_addr", {4'h0, mem_req, mem_we, mem_ds, mem_a}, {4'h0, cap_req, cap_we, cap_ds, cap_a});
        check("hold_data", mem_d, cap_d);
      end
      sd_cnt++;
      if (sd_cnt >= sd_lat) begin
        if (!cap_we) mem_q = {sd_mem[{cap_a[16:1], 1'b1}], sd_mem[{cap_a[16:1], 1'b0}]};
        mem_ack = ~mem_ack;
        sd_busy = 1'b0;
        sd_done++;
      end
    end else if (rst_n && (mem_req !== mem_ack)) begin
      cap_a = mem_a; cap_we = mem_we; cap_ds = mem_ds; cap_d = mem_d; cap_req = mem_req;
      sd_cnt = 0;
      sd_lat = sd_rand ? int'($urandom_range(1, 6)) : 5;
      sd_busy = 1'b1;
      log_a.push_back(mem_a); log_we.push_back(mem_we); log_ds.push_back(mem_ds); log_d.push_back(mem_d);
      if (mem_a >= 24'(FDC_BASE)) fdc_seen = cyc;
      if (mem_we) begin
        if (mem_ds[0]) sd_mem[{mem_a[16:1], 1'b0}] = mem_d[7:0];
        if (mem_ds[1]) sd_mem[{mem_a[16:1], 1'b1}] = mem_d[15:8];
      end
      $display("txn %0d: a=%06h we=%0b ds=%02b d=%04h lat=%0d", log_a.size(), mem_a, mem_we, mem_ds, mem_d, sd_lat);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int target, input string tag);
    for (int i = 0; i < 300 && sd_done < target; i++) tick();
    check(tag, 32'(sd_done >= target), 32'd1);
    tick();
    tick();
  endtask

  task automatic issue(input bit dc, input bit cw, input logic [15:0] ca, input logic [7:0] cd,
                       input bit df, input bit fw, input logic [15:0] fa, input logic [7:0] fd);
    if (dc) begin
      cpu_cs = 1'b1; cpu_oe = !cw; cpu_we = cw; cpu_ad = ca; cpu_d = cd;
      if (cw) ref_mem[int'(ca)] = cd;
    end
    if (df) begin
      fdc_req = 1'b1; fdc_we = fw; fdc_ad = fa; fdc_d = fd;
      if (fw) ref_mem[int'(FDC_BASE) + int'(fa)] = fd;
    end
    tick();
    cpu_cs = 1'b0; cpu_oe = 1'b0; cpu_we = 1'b0; fdc_req = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, done0, ack0, t0, w;
    logic [15:0] ca, fa;
    logic [7:0] cd, fd;
    bit cw, fw;
    int kind;

    for (int i = 0; i < 131072; i++) begin
      sd_mem[i]  = 8'(i * 13 + 7);
      ref_mem[i] = 8'(i * 13 + 7);
    end
    sd_mem[16'h1234] = 8'h12; ref_mem[16'h1234] = 8'h12;
    sd_mem[16'h1235] = 8'hAB; ref_mem[16'h1235] = 8'hAB;

    // Reset held with mem_ack high, then released just before a rising edge.
    repeat (3) tick();
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_bus", {mem_we, mem_ds, mem_d, mem_a}, 43'd0);
    check("rst_outs", {cpu_q, fdc_q, fdc_ack, fdc_overrun}, 18'd0);
    @(negedge clk); #1 rst_n = 1'b1;
    tick();
    check("init_resync", mem_req, 1'b1);
    repeat (10) tick();
    check("idle_no_req", 32'(log_a.size()), 32'd0);
    check("idle_req_level", mem_req, 1'b1);

    // CPU read with rising cs&oe.
    issue(1, 0, 16'h1235, 8'h00, 0, 0, 16'h0, 8'h0);
    wait_done(1, "cpu_rd_done");
    check("cpu_rd_ds", mem_ds, 2'b11);
    check("cpu_rd_a", mem_a, 24'h001235);
    check("cpu_rd_q", cpu_q, 8'hAB);

    // CPU write: single toggle, low lane, replicated data, cpu_q untouched.
    base = log_a.size(); done0 = sd_done;
    issue(1, 1, 16'h0400, 8'h5A, 0, 0, 16'h0, 8'h0);
    wait_done(done0 + 1, "cpu_wr_done");
    repeat (5) tick();
    check("cpu_wr_toggles", 32'(log_a.size() - base), 32'd1);
    check("cpu_wr_we", mem_we, 1'b1);
    check("cpu_wr_ds", mem_ds, 2'b01);
    check("cpu_wr_d", mem_d, 16'h5A5A);
    check("cpu_wr_keeps_q", cpu_q, 8'hAB);

    // Simultaneous CPU read event and FDC write: CPU goes first.
    base = log_a.size(); done0 = sd_done; ack0 = ack_cnt;
    issue(1, 0, 16'h2001, 8'h00, 1, 1, 16'h0010, 8'h77);
    wait_done(done0 + 2, "both_done");
    check("both_first_cpu", log_a[base], 24'h002001);
    check("both_then_fdc", log_a[base + 1], 24'h010010);
    check("both_fdc_wr", {log_we[base + 1], log_ds[base + 1], log_d[base + 1]}, {1'b1, 2'b01, 16'h7777});
    check("both_fdc_ack", 32'(ack_cnt - ack0), 32'd1);
    check("both_cpu_q", cpu_q, ref_mem[16'h2001]);

    // Starvation: CPU read address moves every 4 cycles while an FDC request waits.
    ack0 = ack_cnt; fdc_seen = -1; t0 = cyc;
    fdc_req = 1'b1; fdc_we = 1'b1; fdc_ad = 16'h0100; fdc_d = 8'h33;
    ref_mem[int'(FDC_BASE) + 16'h0100] = 8'h33;
    cpu_cs = 1'b1; cpu_oe = 1'b1; cpu_ad = 16'h3000;
    tick();
    fdc_req = 1'b0;
    for (int k = 1; k < 150 && fdc_seen < 0; k++) begin
      if (k % 4 == 0) cpu_ad = cpu_ad + 16'(1 + $urandom_range(0, 255));
      tick();
    end
    w = fdc_seen - t0;
    $display("starvation: fdc granted after %0d cycles", w);
    check("starve_granted", 32'(fdc_seen >= 0), 32'd1);
    check("starve_window", 32'(w >= 60 && w <= STARVE_MAX + 12), 32'd1);
    cpu_cs = 1'b0; cpu_oe = 1'b0;
    repeat (30) tick();
    check("starve_fdc_ack", 32'(ack_cnt - ack0), 32'd1);

    // Second FDC request while the first is in flight.
    check("overrun_clear", fdc_overrun, 1'b0);
    base = log_a.size(); done0 = sd_done; ack0 = ack_cnt;
    issue(0, 0, 16'h0, 8'h0, 1, 0, 16'h0021, 8'h00);
    tick();
    tick();
    issue(0, 0, 16'h0, 8'h0, 1, 1, 16'h0055, 8'hEE);
    ref_mem[int'(FDC_BASE) + 16'h0055] = sd_mem[int'(FDC_BASE) + 16'h0055];
    check("overrun_set", fdc_overrun, 1'b1);
    wait_done(done0 + 1, "overrun_done");
    repeat (8) tick();
    check("overrun_one_toggle", 32'(log_a.size() - base), 32'd1);
    check("overrun_one_ack", 32'(ack_cnt - ack0), 32'd1);
    check("fdc_rd_q", fdc_q, ref_mem[int'(FDC_BASE) + 16'h0021]);
    check("overrun_sticky", fdc_overrun, 1'b1);

    // Reset in the middle of a CPU write.
    issue(1, 1, 16'h0300, 8'h99, 0, 0, 16'h0, 8'h0);
    tick();
    tick();
    check("midwr_we_before", mem_we, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midwr_we_abort", mem_we, 1'b0);
    check("midwr_req_abort", mem_req, 1'b0);
    check("midwr_overrun_clr", fdc_overrun, 1'b0);
    repeat (10) tick();
    @(negedge clk); #1 rst_n = 1'b1;
    tick();
    check("midwr_resync", mem_req, mem_ack);

    // Reset in the middle of a CPU read: its data must not reach cpu_q.
    issue(1, 0, 16'h1235, 8'h00, 0, 0, 16'h0, 8'h0);
    tick();
    tick();
    rst_n = 1'b0;
    repeat (10) tick();
    check("midrd_q_reset", cpu_q, 8'h00);
    @(negedge clk); #1 rst_n = 1'b1;
    tick();
    check("midrd_resync", mem_req, mem_ack);
    repeat (5) tick();
    check("midrd_no_stale", cpu_q, 8'h00);

    // Randomized traffic against the reference memory.
    sd_rand = 1'b1;
    for (int it = 0; it < 40; it++) begin
      kind = int'($urandom_range(0, 2));
      cw = 1'($urandom_range(0, 1)); fw = 1'($urandom_range(0, 1));
      ca = 16'($urandom); fa = 16'($urandom);
      cd = 8'($urandom); fd = 8'($urandom);
      base = log_a.size(); done0 = sd_done; ack0 = ack_cnt;
      issue(kind != 1, cw, ca, cd, kind != 0, fw, fa, fd);
      wait_done(done0 + ((kind == 2) ? 2 : 1), "rnd_done");
      if (kind != 1) begin
        check("rnd_cpu_a", log_a[base], 24'(ca));
        check("rnd_cpu_ds", log_ds[base], cw ? (ca[0] ? 2'b10 : 2'b01) : 2'b11);
        if (cw) check("rnd_cpu_d", log_d[base], {cd, cd});
        else    check("rnd_cpu_q", cpu_q, ref_mem[int'(ca)]);
      end
      if (kind != 0) begin
        check("rnd_fdc_a", log_a[base + ((kind == 2) ? 1 : 0)], 24'(FDC_BASE + 32'(fa)));
        check("rnd_fdc_ack", 32'(ack_cnt - ack0), 32'd1);
        if (!fw) check("rnd_fdc_q", fdc_q, ref_mem[int'(FDC_BASE) + int'(fa)]);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
